// File: rtl/xor_decode_rx_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// xor_decode_rx_pkg : shared widths, defaults and FIFO helpers for the XOR link
// Rev 1.0
// ----------------------------------------------------------------------------
package xor_decode_rx_pkg;

    localparam int W_DEFAULT     = 10;
    localparam int DEPTH_DEFAULT = 4;

    // Combined push/pop operation seen by the FIFO on a given edge.
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : xor_decode_rx_pkg
`default_nettype wire

// File: rtl/xor_rx_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// xor_rx_fifo : power-of-two circular buffer with occupancy count
// Rev 1.0
// ----------------------------------------------------------------------------
module xor_rx_fifo
    import xor_decode_rx_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int PW   = ptr_width(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  push_data_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o,
    output logic [W-1:0]  rd_data_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_w;
    logic          empty_w;
    logic          pop_en_w;
    logic          wr_en_w;
    fifo_op_e      op_w;

    assign full_w   = (count_q == CW'(DEPTH));
    assign empty_w  = (count_q == '0);

    // A push into a full buffer only lands when the same edge frees a slot.
    assign pop_en_w = pop_i && !empty_w;
    assign wr_en_w  = push_i && (!full_w || pop_en_w);
    assign op_w     = fifo_op_e'({wr_en_w, pop_en_w});

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        case (op_w)
            FIFO_PUSH: begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                count_d  = count_q + CW'(1);
            end
            FIFO_POP: begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                count_d  = count_q - CW'(1);
            end
            FIFO_BOTH: begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left uninitialised; only the pointers define what is live.
    always_ff @(posedge clk) begin
        if (wr_en_w) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign full_o    = full_w;
    assign empty_o   = empty_w;
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

endmodule : xor_rx_fifo
`default_nettype wire

// File: rtl/xor_decode_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// xor_decode_rx : XOR decode stage feeding an output FIFO with sticky overflow
// Rev 1.0
// ----------------------------------------------------------------------------
module xor_decode_rx
    import xor_decode_rx_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [W-1:0]  in_y,
    input  logic [W-1:0]  in_key,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] count,
    output logic          overflow,
    input  logic          clr_ovf
);

    logic          stage_vld_q, stage_vld_d;
    logic [W-1:0]  stage_data_q, stage_data_d;
    logic          overflow_q, overflow_d;

    logic          fifo_full_w;
    logic          fifo_empty_w;
    logic          fifo_push_w;
    logic          fifo_pop_w;
    logic          ovf_evt_w;
    logic [CW-1:0] fifo_count_w;
    logic [W-1:0]  fifo_rd_data_w;

    assign fifo_pop_w  = out_ready && !fifo_empty_w;
    assign fifo_push_w = stage_vld_q && (!fifo_full_w || fifo_pop_w);
    assign ovf_evt_w   = stage_vld_q && fifo_full_w && !fifo_pop_w;

    always_comb begin
        stage_vld_d  = in_valid;
        stage_data_d = in_y ^ in_key;
        // A fresh drop outranks a clear arriving on the same edge.
        overflow_d   = (overflow_q && !clr_ovf) || ovf_evt_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_vld_q  <= 1'b0;
            stage_data_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            stage_vld_q  <= stage_vld_d;
            stage_data_q <= stage_data_d;
            overflow_q   <= overflow_d;
        end
    end

    xor_rx_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push_w),
        .push_data_i (stage_data_q),
        .pop_i       (fifo_pop_w),
        .full_o      (fifo_full_w),
        .empty_o     (fifo_empty_w),
        .count_o     (fifo_count_w),
        .rd_data_o   (fifo_rd_data_w)
    );

    assign out_valid = !fifo_empty_w;
    assign out_data  = fifo_rd_data_w;
    assign count     = fifo_count_w;
    assign overflow  = overflow_q;

endmodule : xor_decode_rx
`default_nettype wire

// File: tb/tb_xor_decode_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_xor_decode_rx : queue-based reference model plus directed and random traffic
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_xor_decode_rx;

    localparam int W     = 10;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_y = '0;
    logic [W-1:0]  in_key = '0;
    logic          out_ready = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [CW-1:0] count;
    logic          overflow;

    int n_tests = 0;
    int n_fail  = 0;

    xor_decode_rx #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_y      (in_y),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one pending decoded word plus an ordered queue of buffered words.
    logic [W-1:0] exp_q[$];
    logic         m_stg_vld = 1'b0;
    logic [W-1:0] m_stg_data = '0;
    logic         m_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_stg_vld  = 1'b0;
            m_stg_data = '0;
            m_ovf      = 1'b0;
        end else begin
            logic did_pop;
            logic dropped;
            did_pop = out_ready && (exp_q.size() > 0);
            dropped = 1'b0;
            if (did_pop) void'(exp_q.pop_front());
            if (m_stg_vld) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(m_stg_data);
                else dropped = 1'b1;
            end
            m_ovf      = (m_ovf && !clr_ovf) || dropped;
            m_stg_vld  = in_valid;
            m_stg_data = in_y ^ in_key;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model out_valid", out_valid, (exp_q.size() != 0));
            chk("model count", count, exp_q.size());
            chk("model overflow", overflow, m_ovf);
            if (exp_q.size() != 0) chk("model out_data", out_data, exp_q[0]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] y, input logic [W-1:0] k);
        in_valid = v;
        in_y     = y;
        in_key   = k;
    endtask

    initial begin
        repeat (3) cyc();
        chk("reset out_valid", out_valid, 0);
        chk("reset count", count, 0);
        chk("reset overflow", overflow, 0);
        rst_n = 1'b1;
        cyc();

        // Single word, two-cycle latency
        out_ready = 1'b1;
        drive(1'b1, 10'h2A5, 10'h0F0);
        cyc();
        chk("single lat1 out_valid", out_valid, 0);
        drive(1'b0, '0, '0);
        cyc();
        chk("single lat2 out_valid", out_valid, 1);
        chk("single out_data", out_data, 10'h255);
        cyc();
        chk("single count after pop", count, 0);

        // Back-to-back fill then ordered drain
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, W'(k) ^ 10'h3FF, 10'h3FF);
            cyc();
        end
        drive(1'b0, '0, '0);
        cyc();
        chk("b2b count full", count, 4);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("b2b order", out_data, k);
            cyc();
        end
        chk("b2b drained", out_valid, 0);

        // Overflow on fifth word, then clear
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, W'(10'h100 + k), '0);
            cyc();
        end
        drive(1'b0, '0, '0);
        cyc();
        chk("ovf flag set", overflow, 1);
        chk("ovf count", count, 4);
        clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        chk("ovf cleared", overflow, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("ovf kept order", out_data, 10'h100 + k);
            cyc();
        end
        chk("ovf fifth dropped", out_valid, 0);

        // Overflow coincident with clear: set wins
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, W'(k), 10'h055);
            cyc();
        end
        clr_ovf = 1'b1;
        drive(1'b0, '0, '0);
        cyc();
        clr_ovf = 1'b0;
        chk("collision overflow", overflow, 1);
        clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        out_ready = 1'b1;
        repeat (6) cyc();

        // Full with simultaneous push and pop
        out_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            out_ready = (k >= 5);
            drive(1'b1, W'(10'h200 + k), '0);
            cyc();
        end
        drive(1'b0, '0, '0);
        chk("full push+pop count", count, 4);
        chk("full push+pop no ovf", overflow, 0);
        repeat (8) cyc();

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, W'(10'h030 + k), '0);
            cyc();
        end
        drive(1'b1, 10'h033, '0);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("rst mid out_valid", out_valid, 0);
        chk("rst mid count", count, 0);
        drive(1'b0, '0, '0);
        cyc();
        rst_n = 1'b1;
        cyc();
        out_ready = 1'b1;
        drive(1'b1, 10'h001, 10'h000);
        cyc();
        drive(1'b0, '0, '0);
        cyc();
        chk("post-rst out_valid", out_valid, 1);
        chk("post-rst out_data", out_data, 10'h001);
        cyc();

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, W'($urandom), W'($urandom));
            out_ready = (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr_ovf   = ($urandom_range(0, 15) == 0);
            cyc();
        end
        drive(1'b0, '0, '0);
        clr_ovf   = 1'b0;
        out_ready = 1'b1;
        repeat (8) cyc();
        chk("final drained", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_xor_decode_rx
`default_nettype wire
